stream_fifo_sync: RTL and testbench

- Single-clock valid/ready FIFO for buffering streams inside one clock domain.
- Typical use: on the destination side of the gray-pointer CDC FIFO, absorbing bursts the downstream consumer cannot take immediately.
- Also usable as a general rate-decoupling buffer.
- Supports any depth ≥1, including non-power-of-2, an optional fall-through mode, a synchronous flush, and a fill-level output.

---
 rtl/stream_fifo_sync.sv | 118 +++++++++++
 tb/tb_stream_fifo_sync.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_sync.sv
// Single-clock valid/ready FIFO with arbitrary depth, optional fall-through,
// synchronous flush and a registered fill-level output.
module stream_fifo_sync #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH-1:0] dst_data_o,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [CNT_W-1:0]      usage_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]     rptr;
    logic [CNT_W-1:0]      cnt;

    logic full;
    logic empty;
    logic ft_empty;
    logic push;
    logic pop;
    logic bypass;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    // Flags, handshakes and output muxing; ready depends only on stored count.
    always_comb begin
        full        = (cnt == FULL_CNT);
        empty       = (cnt == '0);
        ft_empty    = FALL_THROUGH && empty;
        src_ready_o = !full;
        dst_valid_o = (!empty || (FALL_THROUGH && src_valid_i)) && !flush_i;
        dst_data_o  = ft_empty ? src_data_i : mem[rptr];
        push        = src_valid_i && src_ready_o && !flush_i;
        pop         = dst_valid_o && dst_ready_i;
        // Empty fall-through word consumed in the same cycle never touches storage.
        bypass      = ft_empty && push && pop;
        usage_o     = cnt;
    end

    // Pointer and occupancy bookkeeping, with flush returning everything to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (!bypass) begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Storage write; contents survive a flush but are cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !bypass) begin
            mem[wptr] <= src_data_i;
        end
    end

`ifndef SYNTHESIS
    logic                  hold_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    // Remembers a stalled output word so its stability can be confirmed next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_q      <= dst_valid_o && !dst_ready_i;
            hold_data_q <= dst_data_o;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty && !FALL_THROUGH));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt <= FULL_CNT);
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (hold_q && !flush_i) |-> (dst_data_o == hold_data_q));
`endif

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Bench for stream_fifo_sync: three instances (D4/FT0, D5/FT0, D4/FT1) checked
// against directed expectations and a shift-array reference model.
module tb_stream_fifo_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src_data  [3];
    logic       src_valid [3];
    logic       src_ready [3];
    logic [7:0] dst_data  [3];
    logic       dst_valid [3];
    logic       dst_ready [3];
    logic       flush     [3];
    logic [2:0] usage     [3];

    int errors = 0;
    int checks = 0;

    // Reference model: entry 0 is always the oldest word.
    logic [7:0] m_data [3][8];
    int         m_cnt  [3];

    always #5 clk = ~clk;

    stream_fifo_sync #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
        .src_data_i(src_data[0]), .src_valid_i(src_valid[0]), .src_ready_o(src_ready[0]),
        .dst_data_o(dst_data[0]), .dst_valid_o(dst_valid[0]), .dst_ready_i(dst_ready[0]),
        .usage_o(usage[0]));

    stream_fifo_sync #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
        .src_data_i(src_data[1]), .src_valid_i(src_valid[1]), .src_ready_o(src_ready[1]),
        .dst_data_o(dst_data[1]), .dst_valid_o(dst_valid[1]), .dst_ready_i(dst_ready[1]),
        .usage_o(usage[1]));

    stream_fifo_sync #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]),
        .src_data_i(src_data[2]), .src_valid_i(src_valid[2]), .src_ready_o(src_ready[2]),
        .dst_data_o(dst_data[2]), .dst_valid_o(dst_valid[2]), .dst_ready_i(dst_ready[2]),
        .usage_o(usage[2]));

    function automatic int dep(input int i);
        return (i == 1) ? 5 : 4;
    endfunction

    function automatic bit ft(input int i);
        return (i == 2);
    endfunction

    function automatic bit exp_ready(input int i);
        return m_cnt[i] < dep(i);
    endfunction

    function automatic bit exp_valid(input int i);
        return !flush[i] && (m_cnt[i] > 0 || (ft(i) && src_valid[i]));
    endfunction

    function automatic logic [7:0] exp_data(input int i);
        return (m_cnt[i] > 0) ? m_data[i][0] : src_data[i];
    endfunction

    // Apply the handshake rules for the coming edge to the model.
    task automatic model_update(input int i);
        bit push;
        bit pop;
        push = src_valid[i] && exp_ready(i) && !flush[i];
        pop  = exp_valid(i) && dst_ready[i];
        if (flush[i]) begin
            m_cnt[i] = 0;
        end else if (!(m_cnt[i] == 0 && pop)) begin
            if (pop) begin
                for (int k = 0; k < 7; k++) m_data[i][k] = m_data[i][k+1];
                m_cnt[i]--;
            end
            if (push) begin
                m_data[i][m_cnt[i]] = src_data[i];
                m_cnt[i]++;
            end
        end
    endtask

    task automatic drive(input int i, input bit v, input logic [7:0] d, input bit r, input bit fl);
        src_valid[i] = v;
        src_data[i]  = d;
        dst_ready[i] = r;
        flush[i]     = fl;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        for (int i = 0; i < 3; i++) model_update(i);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++; if (src_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got=%b exp=1", i, src_ready[i]); end
            checks++; if (dst_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got=%b exp=0", i, dst_valid[i]); end
            checks++; if (usage[i] !== 3'd0) begin errors++; $display("FAIL reset_usage[%0d] got=%0d exp=0", i, usage[i]); end
            checks++; if (dst_data[i] !== 8'h00) begin errors++; $display("FAIL reset_data[%0d] got=%h exp=00", i, dst_data[i]); end
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
            #2;
            checks++; if (usage[0] !== 3'(k)) begin errors++; $display("FAIL fill_usage got=%0d exp=%0d", usage[0], k); end
            checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL fill_ready got=%b exp=1", src_ready[0]); end
            checks++; if (dst_valid[0] !== (k > 0)) begin errors++; $display("FAIL fill_valid got=%b exp=%b", dst_valid[0], k > 0); end
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[0] !== 3'd4) begin errors++; $display("FAIL full_usage got=%0d exp=4", usage[0]); end
        checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", src_ready[0]); end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
            #2;
            checks++; if (dst_valid[0] !== 1'b1) begin errors++; $display("FAIL drain_valid got=%b exp=1", dst_valid[0]); end
            checks++; if (dst_data[0] !== 8'(8'hA0 + k)) begin errors++; $display("FAIL drain_data got=%h exp=%h", dst_data[0], 8'(8'hA0 + k)); end
            checks++; if (usage[0] !== 3'(4 - k)) begin errors++; $display("FAIL drain_usage got=%0d exp=%0d", usage[0], 4 - k); end
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[0] !== 3'd0) begin errors++; $display("FAIL drained_usage got=%0d exp=0", usage[0]); end
        checks++; if (dst_valid[0] !== 1'b0) begin errors++; $display("FAIL drained_valid got=%b exp=0", dst_valid[0]); end
    endtask

    task automatic test_stream_wrap();
        logic [7:0] w [12];
        for (int k = 0; k < 12; k++) w[k] = 8'($urandom);
        for (int k = 0; k <= 12; k++) begin
            drive(1, k < 12, (k < 12) ? w[k] : 8'h00, 1'b1, 1'b0);
            #2;
            if (k == 0) begin
                checks++; if (dst_valid[1] !== 1'b0) begin errors++; $display("FAIL stream_first_valid got=%b exp=0", dst_valid[1]); end
            end else begin
                checks++; if (dst_valid[1] !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, dst_valid[1]); end
                checks++; if (dst_data[1] !== w[k-1]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, dst_data[1], w[k-1]); end
                checks++; if (usage[1] !== 3'd1) begin errors++; $display("FAIL stream_usage[%0d] got=%0d exp=1", k, usage[1]); end
            end
            tick();
        end
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[1] !== 3'd0) begin errors++; $display("FAIL stream_end_usage got=%0d exp=0", usage[1]); end
        checks++; if (dst_valid[1] !== 1'b0) begin errors++; $display("FAIL stream_end_valid got=%b exp=0", dst_valid[1]); end
    endtask

    task automatic test_fall_through();
        drive(2, 1'b1, 8'h55, 1'b1, 1'b0);
        #2;
        checks++; if (dst_valid[2] !== 1'b1) begin errors++; $display("FAIL ft_valid got=%b exp=1", dst_valid[2]); end
        checks++; if (dst_data[2] !== 8'h55) begin errors++; $display("FAIL ft_data got=%h exp=55", dst_data[2]); end
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[2] !== 3'd0) begin errors++; $display("FAIL ft_bypass_usage got=%0d exp=0", usage[2]); end
        checks++; if (dst_valid[2] !== 1'b0) begin errors++; $display("FAIL ft_after_valid got=%b exp=0", dst_valid[2]); end
        drive(2, 1'b1, 8'h66, 1'b0, 1'b0);
        #2;
        checks++; if (dst_data[2] !== 8'h66) begin errors++; $display("FAIL ft_stall_data got=%h exp=66", dst_data[2]); end
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[2] !== 3'd1) begin errors++; $display("FAIL ft_stored_usage got=%0d exp=1", usage[2]); end
        checks++; if (dst_data[2] !== 8'h66) begin errors++; $display("FAIL ft_stored_data got=%h exp=66", dst_data[2]); end
        drive(2, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[2] !== 3'd0) begin errors++; $display("FAIL ft_popped_usage got=%0d exp=0", usage[2]); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 8'(8'hB0 + k), 1'b0, 1'b0);
            tick();
        end
        drive(0, 1'b1, 8'hB4, 1'b1, 1'b0);
        #2;
        checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL fpp_ready got=%b exp=0", src_ready[0]); end
        checks++; if (dst_data[0] !== 8'hB0) begin errors++; $display("FAIL fpp_head got=%h exp=b0", dst_data[0]); end
        tick();
        #2;
        checks++; if (usage[0] !== 3'd3) begin errors++; $display("FAIL fpp_usage1 got=%0d exp=3", usage[0]); end
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL fpp_ready2 got=%b exp=1", src_ready[0]); end
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[0] !== 3'd3) begin errors++; $display("FAIL fpp_usage2 got=%0d exp=3", usage[0]); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
            #2;
            checks++; if (dst_data[0] !== 8'(8'hB2 + k)) begin errors++; $display("FAIL fpp_drain got=%h exp=%h", dst_data[0], 8'(8'hB2 + k)); end
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
            tick();
        end
        drive(0, 1'b1, 8'hEE, 1'b0, 1'b1);
        #2;
        checks++; if (dst_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", dst_valid[0]); end
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[0] !== 3'd0) begin errors++; $display("FAIL flush_usage got=%0d exp=0", usage[0]); end
        checks++; if (dst_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_after_valid got=%b exp=0", dst_valid[0]); end
        drive(0, 1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        checks++; if (dst_data[0] !== 8'h77) begin errors++; $display("FAIL flush_next_data got=%h exp=77", dst_data[0]); end
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 8'(8'hD0 + k), 1'b0, 1'b0);
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++; if (usage[0] !== 3'd2) begin errors++; $display("FAIL ar_pre_usage got=%0d exp=2", usage[0]); end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", src_ready[0]); end
        checks++; if (dst_valid[0] !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", dst_valid[0]); end
        checks++; if (usage[0] !== 3'd0) begin errors++; $display("FAIL ar_usage got=%0d exp=0", usage[0]); end
        checks++; if (dst_data[0] !== 8'h00) begin errors++; $display("FAIL ar_data got=%h exp=00", dst_data[0]); end
        #2;
        rst_n = 1'b1;
        drive(0, 1'b1, 8'h3C, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        checks++; if (dst_data[0] !== 8'h3C) begin errors++; $display("FAIL ar_resume_data got=%h exp=3c", dst_data[0]); end
        checks++; if (usage[0] !== 3'd1) begin errors++; $display("FAIL ar_resume_usage got=%0d exp=1", usage[0]); end
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int rdy_pct;
        for (int n = 0; n < 600; n++) begin
            rdy_pct = (n < 200) ? 20 : ((n < 400) ? 80 : 50);
            for (int i = 0; i < 3; i++) begin
                drive(i, $urandom_range(0, 3) != 0, 8'($urandom),
                      $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 39) == 0);
            end
            #2;
            for (int i = 0; i < 3; i++) begin
                checks++; if (src_ready[i] !== exp_ready(i)) begin errors++; $display("FAIL rnd_ready[%0d] n=%0d got=%b exp=%b", i, n, src_ready[i], exp_ready(i)); end
                checks++; if (dst_valid[i] !== exp_valid(i)) begin errors++; $display("FAIL rnd_valid[%0d] n=%0d got=%b exp=%b", i, n, dst_valid[i], exp_valid(i)); end
                checks++; if (usage[i] !== 3'(m_cnt[i])) begin errors++; $display("FAIL rnd_usage[%0d] n=%0d got=%0d exp=%0d", i, n, usage[i], m_cnt[i]); end
                if (exp_valid(i)) begin
                    checks++; if (dst_data[i] !== exp_data(i)) begin errors++; $display("FAIL rnd_data[%0d] n=%0d got=%h exp=%h", i, n, dst_data[i], exp_data(i)); end
                end
            end
            tick();
        end
        idle_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_stream_wrap();
        test_fall_through();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
